// File: rtl/mc_control_unit_if.sv
// Control-unit bus: instruction fields and handshake in, datapath strobes out.
interface mc_control_unit_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic       RegWrite;
    logic       retire;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, Zero, mem_ready,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, retire, illegal
    );

    modport slave (
        output op, funct3, funct7b5, Zero, mem_ready,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               ALUControl, ImmSrc, RegWrite, retire, illegal
    );
endinterface

// File: rtl/mc_control_unit.sv
// Multi-cycle RV32I main controller: sequences fetch/decode/execute/memory/
// writeback and drives the ALU operation select.
module mc_control_unit (
    input  logic              clk,
    input  logic              rst,
    mc_control_unit_if.master bus
);
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        TRAP     = 4'd11
    } state_t;

    state_t     state, next;
    logic       pcw, mw, irw, rw, ret;
    logic       adr, ill;
    logic [1:0] rs, sa, sb, aluop;
    logic [2:0] alu_ctl;
    logic       f3_ok;

    assign f3_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b010) ||
                   (bus.funct3 == 3'b110) || (bus.funct3 == 3'b111);

    // State register; reset parks the controller in FETCH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= next;
    end

    // Next-state and per-state datapath controls.
    always_comb begin
        next  = state;
        pcw   = 1'b0;
        adr   = 1'b0;
        mw    = 1'b0;
        irw   = 1'b0;
        rs    = 2'b00;
        sa    = 2'b00;
        sb    = 2'b00;
        aluop = 2'b00;
        rw    = 1'b0;
        ret   = 1'b0;
        ill   = 1'b0;
        case (state)
            FETCH: begin
                sb  = 2'b10;
                rs  = 2'b10;
                irw = bus.mem_ready;
                pcw = bus.mem_ready;
                if (bus.mem_ready) next = DECODE;
            end
            DECODE: begin
                sa = 2'b01;
                sb = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: next = MEMADR;
                    7'b0110011: next = f3_ok ? EXECUTER : TRAP;
                    7'b0010011: next = f3_ok ? EXECUTEI : TRAP;
                    7'b1100011: next = (bus.funct3 == 3'b000) ? BEQ : TRAP;
                    7'b1101111: next = JAL;
                    default:    next = TRAP;
                endcase
            end
            MEMADR: begin
                sa   = 2'b10;
                sb   = 2'b01;
                next = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr = 1'b1;
                if (bus.mem_ready) next = MEMWB;
            end
            MEMWB: begin
                rs   = 2'b01;
                rw   = 1'b1;
                ret  = 1'b1;
                next = FETCH;
            end
            MEMWRITE: begin
                adr = 1'b1;
                mw  = 1'b1;
                if (bus.mem_ready) begin
                    ret  = 1'b1;
                    next = FETCH;
                end
            end
            EXECUTER: begin
                sa    = 2'b10;
                aluop = 2'b10;
                next  = ALUWB;
            end
            EXECUTEI: begin
                sa    = 2'b10;
                sb    = 2'b01;
                aluop = 2'b10;
                next  = ALUWB;
            end
            ALUWB: begin
                rw   = 1'b1;
                ret  = 1'b1;
                next = FETCH;
            end
            BEQ: begin
                sa    = 2'b10;
                aluop = 2'b01;
                pcw   = bus.Zero;
                ret   = 1'b1;
                next  = FETCH;
            end
            JAL: begin
                sa   = 2'b01;
                sb   = 2'b10;
                pcw  = 1'b1;
                next = ALUWB;
            end
            TRAP: begin
                ill = 1'b1;
            end
            default: next = FETCH;
        endcase
    end

    // ALU operation decode from ALUOp and the instruction function fields.
    always_comb begin
        alu_ctl = 3'b000;
        case (aluop)
            2'b01: alu_ctl = 3'b001;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  alu_ctl = (bus.funct7b5 & bus.op[5]) ? 3'b001 : 3'b000;
                    3'b010:  alu_ctl = 3'b101;
                    3'b110:  alu_ctl = 3'b011;
                    3'b111:  alu_ctl = 3'b010;
                    default: alu_ctl = 3'b000;
                endcase
            end
            default: alu_ctl = 3'b000;
        endcase
    end

    // Immediate format depends only on the opcode.
    always_comb begin
        case (bus.op)
            7'b0100011: bus.ImmSrc = 2'b01;
            7'b1100011: bus.ImmSrc = 2'b10;
            7'b1101111: bus.ImmSrc = 2'b11;
            default:    bus.ImmSrc = 2'b00;
        endcase
    end

    // Write strobes and retire are gated by reset so nothing fires while it is held.
    assign bus.PCWrite    = pcw & rst;
    assign bus.MemWrite   = mw  & rst;
    assign bus.IRWrite    = irw & rst;
    assign bus.RegWrite   = rw  & rst;
    assign bus.retire     = ret & rst;
    assign bus.AdrSrc     = adr;
    assign bus.ResultSrc  = rs;
    assign bus.ALUSrcA    = sa;
    assign bus.ALUSrcB    = sb;
    assign bus.ALUControl = alu_ctl;
    assign bus.illegal    = ill;
endmodule

// File: tb/tb_mc_control_unit.sv
// Scoreboard bench for mc_control_unit: each stimulus cycle queues the
// expected control vector; a monitor compares on the falling edge.
module tb_mc_control_unit;
  logic clk = 1'b0;
  logic rst;

  mc_control_unit_if bus();

  mc_control_unit dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.master)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw;
    logic       adr;
    logic       mw;
    logic       irw;
    logic [1:0] rs;
    logic [1:0] sa;
    logic [1:0] sb;
    logic [2:0] alu;
    logic [1:0] imm;
    logic       rw;
    logic       ret;
    logic       ill;
  } vec_t;

  typedef struct {
    vec_t  exp;
    vec_t  mask;
    string name;
  } item_t;

  item_t      scb[$];
  int         checks = 0;
  int         errors = 0;
  logic [6:0] cur_op;
  logic [2:0] cur_f3;
  logic       cur_f7;
  int         cur_imm;

  // Build an expectation; a negative field value means "don't care".
  function automatic item_t mk(string n, int pcw, int adr, int mw, int irw, int rs,
                               int sa, int sb, int alu, int rw, int ret, int ill);
    item_t it;
    it.name = n;
    it.exp  = '0;
    it.mask = '0;
    if (pcw >= 0) begin it.exp.pcw = pcw[0];   it.mask.pcw = '1; end
    if (adr >= 0) begin it.exp.adr = adr[0];   it.mask.adr = '1; end
    if (mw  >= 0) begin it.exp.mw  = mw[0];    it.mask.mw  = '1; end
    if (irw >= 0) begin it.exp.irw = irw[0];   it.mask.irw = '1; end
    if (rs  >= 0) begin it.exp.rs  = rs[1:0];  it.mask.rs  = '1; end
    if (sa  >= 0) begin it.exp.sa  = sa[1:0];  it.mask.sa  = '1; end
    if (sb  >= 0) begin it.exp.sb  = sb[1:0];  it.mask.sb  = '1; end
    if (alu >= 0) begin it.exp.alu = alu[2:0]; it.mask.alu = '1; end
    if (rw  >= 0) begin it.exp.rw  = rw[0];    it.mask.rw  = '1; end
    if (ret >= 0) begin it.exp.ret = ret[0];   it.mask.ret = '1; end
    if (ill >= 0) begin it.exp.ill = ill[0];   it.mask.ill = '1; end
    it.exp.imm  = cur_imm[1:0];
    it.mask.imm = '1;
    return it;
  endfunction

  // Monitor: compare the DUT's control vector against the queued expectation.
  always @(negedge clk) begin
    item_t it;
    vec_t  act;
    if (scb.size() != 0) begin
      it  = scb.pop_front();
      act = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.ResultSrc,
             bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl, bus.ImmSrc,
             bus.RegWrite, bus.retire, bus.illegal};
      checks++;
      if ((act & it.mask) !== (it.exp & it.mask)) begin
        errors++;
        $display("FAIL %s at %0t: got %b want %b (mask %b)",
                 it.name, $time, act, it.exp, it.mask);
      end
    end
  end

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input int imm);
    cur_op  = op;
    cur_f3  = f3;
    cur_f7  = f7;
    cur_imm = imm;
  endtask

  task automatic step(input logic r, input logic mr, input logic z, input item_t it);
    @(posedge clk);
    #1;
    rst           = r;
    bus.mem_ready = mr;
    bus.Zero      = z;
    bus.op        = cur_op;
    bus.funct3    = cur_f3;
    bus.funct7b5  = cur_f7;
    scb.push_back(it);
  endtask

  task automatic s_fetch(input int mr);
    step(1'b1, mr[0], 1'b0, mk("FETCH", mr, 0, 0, mr, 2, 0, 2, 0, 0, 0, 0));
  endtask
  task automatic s_decode(input logic mr);
    step(1'b1, mr, 1'b1, mk("DECODE", 0, -1, 0, 0, -1, 1, 1, 0, 0, 0, 0));
  endtask
  task automatic s_memadr(input logic mr);
    step(1'b1, mr, 1'b0, mk("MEMADR", 0, -1, 0, 0, -1, 2, 1, 0, 0, 0, 0));
  endtask
  task automatic s_memread(input logic mr);
    step(1'b1, mr, 1'b0, mk("MEMREAD", 0, 1, 0, 0, 0, -1, -1, -1, 0, 0, 0));
  endtask
  task automatic s_memwb();
    step(1'b1, 1'b0, 1'b0, mk("MEMWB", 0, -1, 0, 0, 1, -1, -1, -1, 1, 1, 0));
  endtask
  task automatic s_memwrite(input int mr);
    step(1'b1, mr[0], 1'b0, mk("MEMWRITE", 0, 1, 1, 0, 0, -1, -1, -1, 0, mr, 0));
  endtask
  task automatic s_exec(input int srcb, input int alu);
    step(1'b1, 1'b0, 1'b0, mk("EXECUTE", 0, -1, 0, 0, -1, 2, srcb, alu, 0, 0, 0));
  endtask
  task automatic s_aluwb();
    step(1'b1, 1'b1, 1'b0, mk("ALUWB", 0, -1, 0, 0, 0, -1, -1, -1, 1, 1, 0));
  endtask
  task automatic s_beq(input int z);
    step(1'b1, 1'b0, z[0], mk("BEQ", z, -1, 0, 0, 0, 2, 0, 1, 0, 1, 0));
  endtask
  task automatic s_jal();
    step(1'b1, 1'b0, 1'b0, mk("JAL", 1, -1, 0, 0, 0, 1, 2, 0, 0, 0, 0));
  endtask
  task automatic s_trap(input logic mr, input logic z);
    step(1'b1, mr, z, mk("TRAP", 0, -1, 0, 0, -1, -1, -1, -1, 0, 0, 1));
  endtask
  task automatic s_rst(input logic mr);
    step(1'b0, mr, 1'b1, mk("RESET", 0, 0, 0, 0, 2, 0, 2, 0, 0, 0, 0));
  endtask

  initial begin
    rst           = 1'b1;
    bus.op        = '0;
    bus.funct3    = '0;
    bus.funct7b5  = 1'b0;
    bus.Zero      = 1'b0;
    bus.mem_ready = 1'b0;
    set_instr(7'b0110011, 3'b000, 1'b1, 0);
    #2 rst = 1'b0;
    #1;

    // Direct reset-state check while reset is held.
    checks++;
    if (bus.PCWrite !== 1'b0 || bus.MemWrite !== 1'b0 || bus.IRWrite !== 1'b0 ||
        bus.RegWrite !== 1'b0 || bus.retire !== 1'b0 || bus.illegal !== 1'b0 ||
        bus.AdrSrc !== 1'b0 || bus.ALUSrcA !== 2'b00 || bus.ALUSrcB !== 2'b10 ||
        bus.ResultSrc !== 2'b10) begin
      errors++;
      $display("FAIL reset state at %0t: pcw=%b mw=%b irw=%b rw=%b ret=%b ill=%b adr=%b sa=%b sb=%b rs=%b",
               $time, bus.PCWrite, bus.MemWrite, bus.IRWrite, bus.RegWrite, bus.retire,
               bus.illegal, bus.AdrSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ResultSrc);
    end
    repeat (2) @(posedge clk);

    // Reset state: FETCH controls, strobes forced low despite mem_ready.
    s_rst(1'b1);

    // R-type sub.
    s_fetch(1); s_decode(1'b0); s_exec(0, 1); s_aluwb();
    // R-type or / and.
    set_instr(7'b0110011, 3'b110, 1'b0, 0);
    s_fetch(1); s_decode(1'b1); s_exec(0, 3); s_aluwb();
    set_instr(7'b0110011, 3'b111, 1'b0, 0);
    s_fetch(1); s_decode(1'b1); s_exec(0, 2); s_aluwb();
    // I-type slti, and addi with funct7b5 set (must stay add).
    set_instr(7'b0010011, 3'b010, 1'b0, 0);
    s_fetch(1); s_decode(1'b1); s_exec(1, 5); s_aluwb();
    set_instr(7'b0010011, 3'b000, 1'b1, 0);
    s_fetch(1); s_decode(1'b1); s_exec(1, 0); s_aluwb();

    // lw with two stall cycles in MEMREAD.
    set_instr(7'b0000011, 3'b010, 1'b0, 0);
    s_fetch(1); s_decode(1'b0); s_memadr(1'b0);
    s_memread(1'b0); s_memread(1'b0); s_memread(1'b1); s_memwb();

    // sw with a FETCH stall and a MEMWRITE stall.
    set_instr(7'b0100011, 3'b010, 1'b0, 1);
    s_fetch(0); s_fetch(1); s_decode(1'b1); s_memadr(1'b1);
    s_memwrite(0); s_memwrite(1);

    // beq taken / not taken.
    set_instr(7'b1100011, 3'b000, 1'b0, 2);
    s_fetch(1); s_decode(1'b1); s_beq(1);
    s_fetch(1); s_decode(1'b1); s_beq(0);

    // jal.
    set_instr(7'b1101111, 3'b000, 1'b0, 3);
    s_fetch(1); s_decode(1'b1); s_jal(); s_aluwb();

    // Illegal opcode: trap holds for 20 cycles, only reset leaves.
    set_instr(7'b0000000, 3'b000, 1'b0, 0);
    s_fetch(1); s_decode(1'b1);
    for (int unsigned i = 0; i < 20; i++) s_trap(i[0], 1'b1);
    s_rst(1'b1);

    // R-type with unsupported funct3.
    set_instr(7'b0110011, 3'b001, 1'b0, 0);
    s_fetch(1); s_decode(1'b1);
    for (int unsigned i = 0; i < 20; i++) s_trap(1'b1, i[1]);
    s_rst(1'b0);

    // Branch with funct3 other than beq.
    set_instr(7'b1100011, 3'b001, 1'b0, 2);
    s_fetch(1); s_decode(1'b1);
    s_trap(1'b1, 1'b1); s_trap(1'b1, 1'b1);
    s_rst(1'b1);

    // Reset asserted mid-MEMWRITE while stalled, then a clean sw.
    set_instr(7'b0100011, 3'b010, 1'b0, 1);
    s_fetch(1); s_decode(1'b1); s_memadr(1'b1); s_memwrite(0);
    s_rst(1'b0); s_rst(1'b1);
    s_fetch(1); s_decode(1'b1); s_memadr(1'b1); s_memwrite(1);

    // Back to normal after the aborted store.
    set_instr(7'b0110011, 3'b000, 1'b0, 0);
    s_fetch(1); s_decode(1'b1); s_exec(0, 0); s_aluwb();

    // Bounded wait for the monitor to consume every expectation.
    fork
      wait (scb.size() == 0);
      repeat (20) @(posedge clk);
    join_any
    disable fork;
    checks++;
    if (scb.size() != 0) begin
      errors++;
      $display("FAIL timeout at %0t: %0d expectations never checked", $time, scb.size());
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
